// File: rtl/id_issue_stage.sv
// ID/EX issue stage: resolves operands through priority forwarding, registers the
// decoded instruction for EX, and interlocks load-use hazards with a countdown.
module id_issue_stage #(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 4,
  parameter int CTRL_W   = 8,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_valid,
  input  logic [CTRL_W-1:0]           dec_ctrl,
  input  logic                        dec_re0,
  input  logic                        dec_re1,
  input  logic [RADDR_W-1:0]          dec_raddr0,
  input  logic [RADDR_W-1:0]          dec_raddr1,
  input  logic [DATA_W-1:0]           dec_rdata0,
  input  logic [DATA_W-1:0]           dec_rdata1,
  input  logic [DATA_W-1:0]           dec_opnd0,
  input  logic [DATA_W-1:0]           dec_opnd1,
  input  logic                        dec_we,
  input  logic [RADDR_W-1:0]          dec_waddr,
  input  logic                        dec_is_load,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*RADDR_W-1:0]  fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic                        ex_ready,
  input  logic                        flush,
  output logic                        dec_ready,
  output logic                        stall_req,
  output logic                        ex_valid,
  output logic [CTRL_W-1:0]           ex_ctrl,
  output logic [DATA_W-1:0]           ex_opnd0,
  output logic [DATA_W-1:0]           ex_opnd1,
  output logic                        ex_we,
  output logic [RADDR_W-1:0]          ex_waddr,
  output logic                        ex_is_load
);

  localparam int CNT_W = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

  logic [RADDR_W-1:0] ld_addr;
  logic [CNT_W-1:0]   ld_cnt;
  logic [DATA_W-1:0]  opnd0;
  logic [DATA_W-1:0]  opnd1;
  logic               hazard;
  logic               issue;

  // Scanning from oldest to youngest lets the youngest matching source win.
  function automatic logic [DATA_W-1:0] resolve(
    input logic                       re,
    input logic [RADDR_W-1:0]         raddr,
    input logic [DATA_W-1:0]          rdata,
    input logic [DATA_W-1:0]          opnd,
    input logic [NUM_FWD-1:0]         f_we,
    input logic [NUM_FWD*RADDR_W-1:0] f_waddr,
    input logic [NUM_FWD*DATA_W-1:0]  f_wdata
  );
    logic [DATA_W-1:0] val;
    val = rdata;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (f_we[i] && (f_waddr[i*RADDR_W +: RADDR_W] == raddr)) begin
        val = f_wdata[i*DATA_W +: DATA_W];
      end
    end
    return re ? val : opnd;
  endfunction

  assign opnd0 = resolve(dec_re0, dec_raddr0, dec_rdata0, dec_opnd0,
                         fwd_we, fwd_waddr, fwd_wdata);
  assign opnd1 = resolve(dec_re1, dec_raddr1, dec_rdata1, dec_opnd1,
                         fwd_we, fwd_waddr, fwd_wdata);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    hazard = 1'b0;
    if (dec_valid && (ld_cnt != '0)) begin
      hazard = (dec_re0 && (dec_raddr0 == ld_addr)) ||
               (dec_re1 && (dec_raddr1 == ld_addr));
    end
  end

  assign stall_req = hazard;
  assign dec_ready = (ex_ready && !hazard) || flush;
  assign issue     = !flush && ex_ready && dec_valid && !hazard;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_opnd0   <= '0;
      ex_opnd1   <= '0;
      ex_we      <= 1'b0;
      ex_waddr   <= '0;
      ex_is_load <= 1'b0;
    end else if (flush || (ex_ready && !issue)) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_opnd0   <= '0;
      ex_opnd1   <= '0;
      ex_we      <= 1'b0;
      ex_waddr   <= '0;
      ex_is_load <= 1'b0;
    end else if (issue) begin
      ex_valid   <= 1'b1;
      ex_ctrl    <= dec_ctrl;
      ex_opnd0   <= opnd0;
      ex_opnd1   <= opnd1;
      ex_we      <= dec_we;
      ex_waddr   <= dec_waddr;
      ex_is_load <= dec_is_load;
    end
  end

  // The countdown tracks the load now in EX; flush only discards decode, so it keeps counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt  <= '0;
      ld_addr <= '0;
    end else if (issue && dec_is_load && dec_we) begin
      ld_cnt  <= CNT_W'(LOAD_LAT);
      ld_addr <= dec_waddr;
    end else if (ex_ready && (ld_cnt != '0)) begin
      ld_cnt  <= ld_cnt - CNT_W'(1);
    end
  end

endmodule
